// File: rtl/rca_pkg.sv
// Shared types and defaults for the ripple-carry adder family.
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sadd_state_t;

    localparam int RCA_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder: sum and carry of two bits.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_fa_cell.sv
// Combinational full adder cell built from two half adders and an OR for carry.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0_s;
    logic c0_s;
    logic c1_s;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0_s),
        .c (c0_s)
    );

    half_adder u_ha1 (
        .a (s0_s),
        .b (ci),
        .s (s),
        .c (c1_s)
    );

    assign co = c0_s | c1_s;

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand pair per handshake, summed LSB first
// through a single full-adder cell, result offered downstream on valid/ready.
module bit_serial_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sadd_state_t      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic             fa_s_s;
    logic             fa_co_s;
    logic             last_bit_s;

    serial_fa_cell u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s_s),
        .co (fa_co_s)
    );

    assign last_bit_s = (cnt_q == CW'(WIDTH - 1));

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            a_sh_q   <= {WIDTH{1'b0}};
            b_sh_q   <= {WIDTH{1'b0}};
            sum_sh_q <= {WIDTH{1'b0}};
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
        end
    end

    // Next-state logic of the handshake FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? SHIFT : IDLE;
            SHIFT:   state_d = last_bit_s ? DONE : SHIFT;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accept, one full-adder step per SHIFT cycle, hold otherwise.
    always_comb begin
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    cnt_d    = {CW{1'b0}};
                    sum_sh_d = {WIDTH{1'b0}};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            SHIFT: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                sum_sh_d = {fa_s_s, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_co_s;
                // Counter parks on the last bit so it never wraps mid-operation.
                cnt_d    = last_bit_s ? cnt_q : cnt_q + CW'(1);
            end
            DONE:    cnt_d = cnt_q;
            default: cnt_d = {CW{1'b0}};
        endcase
    end

    // Handshake and result outputs decoded from registered state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_sh_q;
        cout      = carry_q;
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random self-checking bench for bit_serial_adder (WIDTH=4) with a
// cycle-level reference model and a result scoreboard queue.
module tb_bit_serial_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int vectors     = 0;
    int miscompares = 0;
    int accepts     = 0;
    int results     = 0;

    // Reference model state: 0 idle, 1 shifting, 2 done.
    int           m_state = 0;
    int           m_cnt   = 0;
    bit           m_known = 1'b0;
    logic [W:0]   exp_q[$];

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs against the model, update model, advance to next negedge.
    task automatic tick();
        if (m_known) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_state == 0});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_state == 2});
            if (m_state == 2 && exp_q.size() > 0)
                chk("result", {27'd0, cout, sum}, {27'd0, exp_q[0]});
        end
        if (rst) begin
            m_state = 0;
            m_known = 1'b1;
            exp_q.delete();
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
                    accepts++;
                    m_cnt   = 0;
                    m_state = 1;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == W) m_state = 2;
                end
                2: if (out_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    results++;
                    m_state = 0;
                end
                default: m_state = 0;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Accept one op, wait out the shift phase, hold in DONE, then hand off.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input int hold, input logic [W:0] want, input string tag);
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc;
        for (int i = 0; i < W; i++) tick();
        for (int i = 0; i < hold; i++) tick();
        chk(tag, {27'd0, cout, sum}, {27'd0, want});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int res_before;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {28'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);

        run_op(4'h3, 4'h5, 1'b0, 0, 5'h08, "op_3_5");
        run_op(4'hF, 4'h1, 1'b0, 0, 5'h10, "op_F_1");
        run_op(4'hF, 4'hF, 1'b1, 0, 5'h1F, "op_F_F_1");

        // Long stall in DONE; an in_valid alongside the releasing out_ready must not be accepted.
        a = 4'h6; b = 4'h3; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < W + 10; i++) tick();
        chk("stall_sum", {27'd0, cout, sum}, 32'h0A);
        a = 4'h1; b = 4'h1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("after_done_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // in_valid pulse during SHIFT is ignored.
        res_before = results;
        a = 4'h2; b = 4'h2; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; tick();
        a = 4'h7; b = 4'h7; in_valid = 1'b1; tick();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) tick();
        chk("ignore_sum", {27'd0, cout, sum}, 32'h04);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        for (int i = 0; i < W + 2; i++) tick();
        chk("ignore_one_result", results - res_before, 32'd1);

        // Reset at the second SHIFT edge discards the op.
        a = 4'h6; b = 4'h6; in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum", {28'd0, sum}, 32'd0);
        chk("midrst_cout", {31'd0, cout}, 32'd0);
        run_op(4'h9, 4'h9, 1'b0, 2, 5'h12, "op_9_9");

        // Random traffic with random valid/ready gaps.
        res_before = results;
        accepts = 0;
        for (int i = 0; i < 6000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < W + 3; i++) tick();
        chk("drain_empty", exp_q.size(), 32'd0);
        chk("one_result_per_accept", results - res_before, accepts);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
